// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision add path.
//   - binary32 field positions and widths
//   - canonical quiet NaN constant
//   - operand classes and the issue-stage FSM states
//   - helper that flushes a subnormal operand to a signed zero
package fpu_pkg;

    localparam int unsigned FP32_WIDTH    = 32;
    localparam int unsigned FP32_SIGN_BIT = 31;
    localparam int unsigned FP32_EXP_MSB  = 30;
    localparam int unsigned FP32_EXP_LSB  = 23;
    localparam int unsigned FP32_EXP_W    = 8;
    localparam int unsigned FP32_MANT_MSB = 22;
    localparam int unsigned FP32_MANT_W   = 23;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORM,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } add_issue_state_t;

    // Exponent 0 with a nonzero mantissa becomes a zero of the same sign.
    function automatic logic [31:0] flush_subnormal(input logic [31:0] value);
        logic [31:0] flushed;
        flushed = value;
        if ((value[FP32_EXP_MSB:FP32_EXP_LSB] == '0) && (value[FP32_MANT_MSB:0] != '0)) begin
            flushed = {value[FP32_SIGN_BIT], 31'd0};
        end
        return flushed;
    endfunction

endpackage

// File: rtl/fpu_add_issue_classify.sv
// fp32_classify: combinational binary32 operand classifier.
// Ports:
//   value  in   32  binary32 operand
//   cls    out      operand class (fp_class_t)
//   sign   out  1   sign bit of the operand
module fp32_classify
    import fpu_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_t   cls,
    output logic        sign
);

    logic [7:0]  exp_f;
    logic [22:0] mant_f;

    assign exp_f  = value[FP32_EXP_MSB:FP32_EXP_LSB];
    assign mant_f = value[FP32_MANT_MSB:0];
    assign sign   = value[FP32_SIGN_BIT];

    always_comb begin
        cls = NORMAL;
        if (exp_f == 8'hFF) begin
            if (mant_f == '0) begin
                cls = INF;
            end else if (mant_f[FP32_MANT_MSB]) begin
                cls = QNAN;
            end else begin
                cls = SNAN;
            end
        end else if (exp_f == 8'h00) begin
            cls = (mant_f == '0) ? ZERO : SUBNORM;
        end
    end

endmodule

// File: rtl/fpu_add_issue.sv
// fpu_add_issue: issue/capture stage around a combinational binary32 adder.
// Takes one add/sub request over valid/ready, registers the adder operands
// (subtract folded into the sign of data2), resolves NaN/infinity operands
// locally and registers the selected result for the consumer.
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   in_valid/in_ready       request handshake
//   in_op, in_a, in_b       0 = a+b, 1 = a-b; binary32 operands
//   add_data1/add_data2     registered operands to the external adder
//   add_result              combinational sum from the adder
//   out_valid/out_ready     result handshake
//   out_result/out_invalid  result and invalid-operation flag
module fpu_add_issue
    import fpu_pkg::*;
#(
    parameter bit FTZ = 1'b0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] add_data1,
    output logic [31:0] add_data2,
    input  logic [31:0] add_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_invalid
);

    add_issue_state_t state_q, state_d;
    logic [31:0]      data1_q, data1_d;
    logic [31:0]      data2_q, data2_d;
    logic [31:0]      result_q, result_d;
    logic             invalid_q, invalid_d;

    logic [31:0] op_a, op_b;
    fp_class_t   cls1, cls2;
    logic        sign1, sign2;
    logic [31:0] sel_result;
    logic        sel_invalid;

    // Effective operand B carries the subtract in its sign bit.
    always_comb begin
        op_a = in_a;
        op_b = {in_b[FP32_SIGN_BIT] ^ in_op, in_b[30:0]};
        if (FTZ) begin
            op_a = flush_subnormal(op_a);
            op_b = flush_subnormal(op_b);
        end
    end

    fp32_classify u_class1 (
        .value (data1_q),
        .cls   (cls1),
        .sign  (sign1)
    );

    fp32_classify u_class2 (
        .value (data2_q),
        .cls   (cls2),
        .sign  (sign2)
    );

    // Special operands override the adder; infinities are already canonical
    // encodings, so the infinite operand itself is the result.
    always_comb begin
        sel_result  = add_result;
        sel_invalid = 1'b0;
        if (cls1 inside {QNAN, SNAN} || cls2 inside {QNAN, SNAN}) begin
            sel_result  = FP32_QNAN;
            sel_invalid = (cls1 == SNAN) || (cls2 == SNAN);
        end else if ((cls1 == INF) && (cls2 == INF) && (sign1 != sign2)) begin
            sel_result  = FP32_QNAN;
            sel_invalid = 1'b1;
        end else if (cls1 == INF) begin
            sel_result = data1_q;
        end else if (cls2 == INF) begin
            sel_result = data2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data1_d = op_a;
                    data2_d = op_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d  = sel_result;
                invalid_d = sel_invalid;
                state_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            data1_q   <= '0;
            data2_q   <= '0;
            result_q  <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
        end
    end

    assign add_data1   = data1_q;
    assign add_data2   = data2_q;
    assign out_result  = result_q;
    assign out_invalid = invalid_q;

endmodule

// File: tb/tb_fpu_add_issue.sv
// Self-checking bench for fpu_add_issue. Two instances (FTZ=0 and FTZ=1)
// share the request/handshake inputs; each has its own stub adder that
// returns hand-computed sums for the finite operand pairs used here.
module tb_fpu_add_issue;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_op;
    logic [31:0] in_a, in_b;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_invalid0;
    logic [31:0] add_data1_0, add_data2_0, add_result0, out_result0;
    logic        in_ready1, out_valid1, out_invalid1;
    logic [31:0] add_data1_1, add_data2_1, add_result1, out_result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] stub_add(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h42C86666, 32'h42B50000}: return 32'h433EB333;
            {32'h42C86666, 32'hC2B50000}: return 32'h411B3333;
            {32'h00000001, 32'h3F800000}: return 32'h3F800000;
            {32'h00000000, 32'h3F800000}: return 32'h3F800000;
            {32'h80000005, 32'h3F800000}: return 32'h3F800000;
            {32'h80000000, 32'h3F800000}: return 32'h3F800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    assign add_result0 = stub_add(add_data1_0, add_data2_0);
    assign add_result1 = stub_add(add_data1_1, add_data2_1);

    fpu_add_issue #(.FTZ(1'b0)) dut0 (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready0),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .add_data1   (add_data1_0),
        .add_data2   (add_data2_0),
        .add_result  (add_result0),
        .out_valid   (out_valid0),
        .out_ready   (out_ready),
        .out_result  (out_result0),
        .out_invalid (out_invalid0)
    );

    fpu_add_issue #(.FTZ(1'b1)) dut1 (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready1),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .add_data1   (add_data1_1),
        .add_data2   (add_data2_1),
        .add_result  (add_result1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready),
        .out_result  (out_result1),
        .out_invalid (out_invalid1)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d1_ftz0;
        logic [31:0] d1_ftz1;
        logic [31:0] d2;
        logic [31:0] res;
        logic        inv;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Present a request, wait for the accept edge, then wait for out_valid.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (!in_ready0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_accept", {31'd0, in_ready0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_exec", {31'd0, in_ready0}, 32'd0);
        check("out_valid_early", {31'd0, out_valid0}, 32'd0);
        waited = 0;
        while (!out_valid0 && waited < 2) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        check("out_valid_latency", {31'd0, out_valid0}, 32'd1);
        check("ftz_out_valid", {31'd0, out_valid1}, 32'd1);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_drain", {31'd0, in_ready0}, 32'd1);
        check("out_valid_after_drain", {31'd0, out_valid0}, 32'd0);
    endtask

    initial begin
        //            op    a              b              d1 ftz0        d1 ftz1        d2             result         inv
        vecs[0]  = '{1'b0, 32'h42C86666, 32'h42B50000, 32'h42C86666, 32'h42C86666, 32'h42B50000, 32'h433EB333, 1'b0};
        vecs[1]  = '{1'b1, 32'h42C86666, 32'h42B50000, 32'h42C86666, 32'h42C86666, 32'hC2B50000, 32'h411B3333, 1'b0};
        vecs[2]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1};
        vecs[3]  = '{1'b1, 32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b0};
        vecs[4]  = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7F800001, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1};
        vecs[5]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00001, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0};
        vecs[6]  = '{1'b0, 32'h3F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b0};
        vecs[7]  = '{1'b0, 32'h00000001, 32'h3F800000, 32'h00000001, 32'h00000000, 32'h3F800000, 32'h3F800000, 1'b0};
        vecs[8]  = '{1'b1, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b0};
        vecs[9]  = '{1'b0, 32'h3F800000, 32'hFF800001, 32'h3F800000, 32'h3F800000, 32'hFF800001, 32'h7FC00000, 1'b1};
        vecs[10] = '{1'b0, 32'h80000005, 32'h3F800000, 32'h80000005, 32'h80000000, 32'h3F800000, 32'h3F800000, 1'b0};

        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Reset state
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_out_result", out_result0, 32'd0);
        check("rst_out_invalid", {31'd0, out_invalid0}, 32'd0);
        check("rst_add_data1", add_data1_0, 32'd0);
        check("rst_add_data2", add_data2_0, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_data1", i), add_data1_0, vecs[i].d1_ftz0);
            check($sformatf("v%0d_ftz_data1", i), add_data1_1, vecs[i].d1_ftz1);
            check($sformatf("v%0d_data2", i), add_data2_0, vecs[i].d2);
            check($sformatf("v%0d_result", i), out_result0, vecs[i].res);
            check($sformatf("v%0d_ftz_result", i), out_result1, vecs[i].res);
            check($sformatf("v%0d_invalid", i), {31'd0, out_invalid0}, {31'd0, vecs[i].inv});
            drain();
        end

        // Backpressure: DONE holds while a competing request is presented.
        issue(1'b0, 32'h42C86666, 32'h42B50000);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 1'b1;
        in_a     = 32'h3F800000;
        in_b     = 32'h3F800000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid0}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready0}, 32'd0);
            check("bp_result", out_result0, 32'h433EB333);
            check("bp_data1", add_data1_0, 32'h42C86666);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_in_ready_after", {31'd0, in_ready0}, 32'd1);
        check("bp_out_valid_after", {31'd0, out_valid0}, 32'd0);
        check("bp_no_accept_on_drain", add_data1_0, 32'h42C86666);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_stays", {31'd0, in_ready0}, 32'd1);

        // Reset mid-EXEC discards the in-flight operation.
        in_valid = 1'b1;
        in_op    = 1'b0;
        in_a     = 32'h7F800000;
        in_b     = 32'hFF800000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_rst    = 1'b0;
        check("mid_in_exec", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        check("mid_rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("mid_rst_out_result", out_result0, 32'd0);
        check("mid_rst_out_invalid", {31'd0, out_invalid0}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("mid_rst_data1", add_data1_0, 32'd0);
        check("mid_rst_data2", add_data2_0, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("mid_rst_no_result", {31'd0, out_valid0}, 32'd0);
        end
        issue(1'b1, 32'h42C86666, 32'h42B50000);
        check("post_rst_result", out_result0, 32'h411B3333);
        check("post_rst_data2", add_data2_0, 32'hC2B50000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
